// File: rtl/axis_interpolator_arbiter.sv
// ---------------------------------------------------------------------------
// axis_interpolator_arbiter
//   Lets several AXI-Stream sources take turns using one downstream
//   axis_interpolator. Sources are granted round-robin, and each grant is a
//   burst of cfg_burst samples. The interpolation ratio of the granted source
//   is presented on int_cfg_data. The grant is released only after every
//   interpolator output produced by the burst has been seen on the monitor
//   handshake, so cfg_data never changes under samples that are in flight.
//
// Optional feature macro: AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
//   defined   : a source that stalls for one cycle during its burst loses the
//               grant. The arbiter drains if samples were taken, and returns
//               straight to idle if none were taken.
//   undefined : the burst always runs to cfg_burst samples, however long the
//               source stalls.
//
// Ports
//   aclk, areset    clock, synchronous active-high reset
//   cfg_ratio       per-channel ratio, channel i at [i*CNTR_WIDTH +: CNTR_WIDTH]
//   cfg_burst       samples per grant (0 behaves as 1)
//   s_axis_*        per-channel source streams (tdata/tvalid/tready)
//   m_axis_*        stream toward the interpolator slave port
//   int_cfg_data    interpolator ratio for the current grant
//   mon_tvalid/rdy  interpolator master handshake, observed only
//   grant_id        channel that currently owns the interpolator
//   busy            high while a grant is running or draining
// ---------------------------------------------------------------------------
module axis_interpolator_arbiter #(
  parameter  int unsigned AXIS_TDATA_WIDTH = 32,
  parameter  int unsigned CNTR_WIDTH       = 32,
  parameter  int unsigned BURST_WIDTH      = 16,
  parameter  int unsigned CHANNELS         = 2,
  localparam int unsigned GRANT_WIDTH      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                                 aclk,
  input  logic                                 areset,
  input  logic [CHANNELS*CNTR_WIDTH-1:0]       cfg_ratio,
  input  logic [BURST_WIDTH-1:0]               cfg_burst,
  input  logic [CHANNELS*AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
  input  logic [CHANNELS-1:0]                  s_axis_tvalid,
  output logic [CHANNELS-1:0]                  s_axis_tready,
  output logic [AXIS_TDATA_WIDTH-1:0]          m_axis_tdata,
  output logic                                 m_axis_tvalid,
  input  logic                                 m_axis_tready,
  output logic [CNTR_WIDTH-1:0]                int_cfg_data,
  input  logic                                 mon_tvalid,
  input  logic                                 mon_tready,
  output logic [GRANT_WIDTH-1:0]               grant_id,
  output logic                                 busy
);

  localparam int unsigned PEND_WIDTH = CNTR_WIDTH + BURST_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [GRANT_WIDTH-1:0]      r_grant;
  logic [GRANT_WIDTH-1:0]      r_last_grant;
  logic [CNTR_WIDTH-1:0]       r_cfg;
  logic [BURST_WIDTH-1:0]      r_burst_left;
  logic [PEND_WIDTH-1:0]       r_pending;
`ifdef AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
  logic                        r_taken;
`endif

  logic                        w_any_valid;
  logic [GRANT_WIDTH-1:0]      w_pick;
  logic [GRANT_WIDTH-1:0]      w_cand;
  logic [CNTR_WIDTH-1:0]       w_pick_ratio;
  logic                        w_sel_valid;
  logic [AXIS_TDATA_WIDTH-1:0] w_sel_data;
  logic [BURST_WIDTH-1:0]      w_burst_init;
  logic                        w_m_hs;
  logic                        w_mon_hs;
  logic                        w_grant_now;
  logic                        w_release;
  logic [PEND_WIDTH-1:0]       w_pend_inc;
  logic [PEND_WIDTH-1:0]       w_pend_dec;

  // Round-robin search: first valid channel after the last one served.
  always_comb begin
    w_any_valid = 1'b0;
    w_pick      = '0;
    w_cand      = '0;
    for (int unsigned k = 1; k <= CHANNELS; k++) begin
      w_cand = GRANT_WIDTH'((32'(r_last_grant) + k) % CHANNELS);
      if (!w_any_valid && s_axis_tvalid[w_cand]) begin
        w_any_valid = 1'b1;
        w_pick      = w_cand;
      end
    end
  end

  // Ratio of the candidate channel, plus the stream of the granted channel.
  always_comb begin
    w_pick_ratio = '0;
    w_sel_valid  = 1'b0;
    w_sel_data   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (w_pick == GRANT_WIDTH'(i)) begin
        w_pick_ratio = cfg_ratio[i*CNTR_WIDTH +: CNTR_WIDTH];
      end
      if (r_grant == GRANT_WIDTH'(i)) begin
        w_sel_valid = s_axis_tvalid[i];
        w_sel_data  = s_axis_tdata[i*AXIS_TDATA_WIDTH +: AXIS_TDATA_WIDTH];
      end
    end
  end

  // Zero-latency pass-through while running; everything is closed otherwise.
  always_comb begin
    s_axis_tready = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      s_axis_tready[i] = (r_state == ST_RUN) && (r_grant == GRANT_WIDTH'(i)) && m_axis_tready;
    end
  end

  assign m_axis_tvalid = (r_state == ST_RUN) && w_sel_valid;
  assign m_axis_tdata  = (r_state == ST_RUN) ? w_sel_data : '0;
  assign int_cfg_data  = r_cfg;
  assign grant_id      = r_grant;
  assign busy          = (r_state != ST_IDLE);

  assign w_m_hs       = m_axis_tvalid && m_axis_tready;
  assign w_mon_hs     = mon_tvalid && mon_tready;
  assign w_burst_init = (cfg_burst == '0) ? BURST_WIDTH'(1) : cfg_burst;
  assign w_grant_now  = (r_state == ST_IDLE) && w_any_valid;
  assign w_release    = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  // Each accepted sample produces ratio+1 interpolator outputs.
  assign w_pend_inc = w_m_hs   ? (PEND_WIDTH'(r_cfg) + PEND_WIDTH'(1)) : '0;
  assign w_pend_dec = w_mon_hs ? PEND_WIDTH'(1) : '0;

  // State register.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_m_hs && (r_burst_left == BURST_WIDTH'(1))) begin
          w_state_nxt = ST_DRAIN;
        end
`ifdef AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
        else if (!w_sel_valid) begin
          w_state_nxt = r_taken ? ST_DRAIN : ST_IDLE;
        end
`endif
      end
      ST_DRAIN: begin
        // Interpolator is idle once nothing is owed and it is not accepting input.
        if ((r_pending == '0) && !m_axis_tready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant, configuration and burst/output accounting.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_grant      <= '0;
      r_last_grant <= GRANT_WIDTH'(CHANNELS - 1);
      r_cfg        <= '0;
      r_burst_left <= '0;
      r_pending    <= '0;
`ifdef AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
      r_taken      <= 1'b0;
`endif
    end else begin
      if (w_grant_now) begin
        r_grant      <= w_pick;
        r_cfg        <= w_pick_ratio;
        r_burst_left <= w_burst_init;
`ifdef AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
        r_taken      <= 1'b0;
`endif
      end else if (w_m_hs) begin
        r_burst_left <= r_burst_left - BURST_WIDTH'(1);
`ifdef AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
        r_taken      <= 1'b1;
`endif
      end
      if (w_release) begin
        r_last_grant <= r_grant;
      end
      r_pending <= r_pending + w_pend_inc - w_pend_dec;
    end
  end

endmodule

// File: tb/tb_axis_interpolator_arbiter.sv
module tb_axis_interpolator_arbiter;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 32;
  localparam int unsigned BW = 16;
  localparam int unsigned CH = 2;

  logic            aclk;
  logic            areset;
  logic [CH*CW-1:0] cfg_ratio;
  logic [BW-1:0]   cfg_burst;
  logic [CH*W-1:0] s_axis_tdata;
  logic [CH-1:0]   s_axis_tvalid;
  logic [CH-1:0]   s_axis_tready;
  logic [W-1:0]    m_axis_tdata;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [CW-1:0]   int_cfg_data;
  logic            mon_tvalid;
  logic            mon_tready;
  logic [0:0]      grant_id;
  logic            busy;

  // {busy, grant_id, m_axis_tvalid, s_axis_tready[1:0]}
  logic [4:0]      st;
  assign st = {busy, grant_id, m_axis_tvalid, s_axis_tready};

  int n_vec = 0;
  int n_err = 0;

  axis_interpolator_arbiter #(
    .AXIS_TDATA_WIDTH(W),
    .CNTR_WIDTH      (CW),
    .BURST_WIDTH     (BW),
    .CHANNELS        (CH)
  ) dut (
    .aclk         (aclk),
    .areset       (areset),
    .cfg_ratio    (cfg_ratio),
    .cfg_burst    (cfg_burst),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid),
    .s_axis_tready(s_axis_tready),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .int_cfg_data (int_cfg_data),
    .mon_tvalid   (mon_tvalid),
    .mon_tready   (mon_tready),
    .grant_id     (grant_id),
    .busy         (busy)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge aclk);
    #2;
  endtask

  task automatic test_reset();
    areset        = 1'b1;
    cfg_ratio     = '0;
    cfg_burst     = '0;
    s_axis_tdata  = '0;
    s_axis_tvalid = '0;
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b0;
    mon_tready    = 1'b0;
    tick(); tick(); tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b0_0_0_00, 32'd0}) begin
      n_err++;
      $display("FAIL reset_state: got st=%b cfg=%0d want st=00000 cfg=0", st, int_cfg_data);
    end
    areset = 1'b0;
  endtask

  task automatic test_two_channels();
    cfg_ratio     = {32'd2, 32'd0};
    cfg_burst     = 16'd3;
    m_axis_tready = 1'b1;
    s_axis_tvalid = 2'b11;
    s_axis_tdata  = {32'hB000_0000, 32'hA000_0000};
    #1;
    n_vec++;
    if (st !== 5'b0_0_0_00) begin
      n_err++; $display("FAIL t1_idle: got %b want 00000", st);
    end
    tick();
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata[31:0] = 32'hA000_0000 + 32'(i);
      #1;
      n_vec++;
      if ({st, int_cfg_data, m_axis_tdata} !== {5'b1_0_1_01, 32'd0, 32'hA000_0000 + 32'(i)}) begin
        n_err++;
        $display("FAIL t1_ch0_run%0d: got st=%b cfg=%0d data=%h want st=10101 cfg=0 data=%h",
                 i, st, int_cfg_data, m_axis_tdata, 32'hA000_0000 + 32'(i));
      end
      tick();
    end
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b1;
    mon_tready    = 1'b1;
    #1;
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t1_ch0_drain: got %b want 10000", st);
    end
    tick(); tick(); tick();
    mon_tvalid = 1'b0;
    #1;
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t1_ch0_drain_end: got %b want 10000", st);
    end
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b0_0_0_00, 32'd0}) begin
      n_err++; $display("FAIL t1_ch0_idle: got st=%b cfg=%0d want 00000 cfg=0", st, int_cfg_data);
    end
    m_axis_tready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      s_axis_tdata[63:32] = 32'hB000_0000 + 32'(i);
      #1;
      n_vec++;
      if ({st, int_cfg_data, m_axis_tdata} !== {5'b1_1_1_10, 32'd2, 32'hB000_0000 + 32'(i)}) begin
        n_err++;
        $display("FAIL t1_ch1_run%0d: got st=%b cfg=%0d data=%h want st=11110 cfg=2 data=%h",
                 i, st, int_cfg_data, m_axis_tdata, 32'hB000_0000 + 32'(i));
      end
      tick();
    end
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b1;
    mon_tready    = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b1_1_0_00, 32'd2}) begin
      n_err++; $display("FAIL t1_ch1_after8: got st=%b cfg=%0d want 11000 cfg=2", st, int_cfg_data);
    end
    tick();
    mon_tvalid = 1'b0;
    #1;
    n_vec++;
    if (st !== 5'b1_1_0_00) begin
      n_err++; $display("FAIL t1_ch1_after9: got %b want 11000", st);
    end
    tick();
    n_vec++;
    if (st !== 5'b0_1_0_00) begin
      n_err++; $display("FAIL t1_ch1_idle: got %b want 01000", st);
    end
  endtask

  task automatic test_single_channel();
    s_axis_tvalid = 2'b10;
    cfg_ratio     = {32'd0, 32'd5};
    cfg_burst     = 16'd4;
    for (int b = 0; b < 2; b++) begin
      m_axis_tready = 1'b1;
      #1;
      n_vec++;
      if (st !== 5'b0_1_0_00) begin
        n_err++; $display("FAIL t2_idle%0d: got %b want 01000", b, st);
      end
      tick();
      for (int i = 0; i < 4; i++) begin
        n_vec++;
        if ({st, int_cfg_data} !== {5'b1_1_1_10, 32'd0}) begin
          n_err++;
          $display("FAIL t2_run%0d_%0d: got st=%b cfg=%0d want 11110 cfg=0", b, i, st, int_cfg_data);
        end
        tick();
      end
      m_axis_tready = 1'b0;
      mon_tvalid    = 1'b1;
      mon_tready    = 1'b1;
      #1;
      n_vec++;
      if (st !== 5'b1_1_0_00) begin
        n_err++; $display("FAIL t2_drain%0d: got %b want 11000", b, st);
      end
      tick(); tick(); tick(); tick();
      mon_tvalid = 1'b0;
      tick();
    end
  endtask

  task automatic test_burst_zero();
    cfg_burst     = 16'd0;
    cfg_ratio     = {32'd1, 32'd1};
    s_axis_tvalid = 2'b01;
    m_axis_tready = 1'b1;
    #1;
    n_vec++;
    if (st !== 5'b0_1_0_00) begin
      n_err++; $display("FAIL t3_idle: got %b want 01000", st);
    end
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b1_0_1_01, 32'd1}) begin
      n_err++; $display("FAIL t3_run: got st=%b cfg=%0d want 10101 cfg=1", st, int_cfg_data);
    end
    tick();
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b1;
    mon_tready    = 1'b1;
    #1;
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t3_drain0: got %b want 10000", st);
    end
    tick();
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t3_drain1: got %b want 10000", st);
    end
    tick();
    mon_tvalid = 1'b0;
    #1;
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t3_drain2: got %b want 10000", st);
    end
    tick();
    n_vec++;
    if (st !== 5'b0_0_0_00) begin
      n_err++; $display("FAIL t3_idle_after: got %b want 00000", st);
    end
  endtask

  task automatic test_drain_hold();
    s_axis_tvalid = 2'b11;
    cfg_burst     = 16'd1;
    cfg_ratio     = {32'd7, 32'd1};
    m_axis_tready = 1'b1;
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b1_1_1_10, 32'd7}) begin
      n_err++; $display("FAIL t4_run: got st=%b cfg=%0d want 11110 cfg=7", st, int_cfg_data);
    end
    tick();
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b1;
    mon_tready    = 1'b0;
    cfg_ratio     = {32'd3, 32'd4};
    for (int i = 0; i < 20; i++) begin
      #1;
      n_vec++;
      if ({st, int_cfg_data} !== {5'b1_1_0_00, 32'd7}) begin
        n_err++;
        $display("FAIL t4_hold%0d: got st=%b cfg=%0d want 11000 cfg=7", i, st, int_cfg_data);
      end
      tick();
    end
    mon_tready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    mon_tvalid = 1'b0;
    tick();
    m_axis_tready = 1'b1;
    cfg_burst     = 16'd5;
    #1;
    n_vec++;
    if (st !== 5'b0_1_0_00) begin
      n_err++; $display("FAIL t4_idle: got %b want 01000", st);
    end
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b1_0_1_01, 32'd4}) begin
      n_err++; $display("FAIL t4_next_grant: got st=%b cfg=%0d want 10101 cfg=4", st, int_cfg_data);
    end
  endtask

  task automatic test_reset_mid_run();
    tick();
    n_vec++;
    if (st !== 5'b1_0_1_01) begin
      n_err++; $display("FAIL t5_run1: got %b want 10101", st);
    end
    tick();
    areset = 1'b1;
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b0_0_0_00, 32'd0}) begin
      n_err++; $display("FAIL t5_reset: got st=%b cfg=%0d want 00000 cfg=0", st, int_cfg_data);
    end
    areset    = 1'b0;
    cfg_ratio = {32'd3, 32'd1};
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b1_0_1_01, 32'd1}) begin
      n_err++; $display("FAIL t5_regrant: got st=%b cfg=%0d want 10101 cfg=1", st, int_cfg_data);
    end
    tick(); tick(); tick(); tick();
    n_vec++;
    if (st !== 5'b1_0_1_01) begin
      n_err++; $display("FAIL t5_full_burst: got %b want 10101", st);
    end
    tick();
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t5_drain: got %b want 10000", st);
    end
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b1;
    mon_tready    = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    mon_tvalid = 1'b0;
    tick();
    n_vec++;
    if (st !== 5'b0_0_0_00) begin
      n_err++; $display("FAIL t5_idle: got %b want 00000", st);
    end
  endtask

`ifdef AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
  task automatic test_early_release();
    areset = 1'b1;
    tick();
    areset        = 1'b0;
    cfg_burst     = 16'd8;
    cfg_ratio     = {32'd9, 32'd3};
    s_axis_tvalid = 2'b11;
    m_axis_tready = 1'b1;
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b1_0_1_01, 32'd3}) begin
      n_err++; $display("FAIL t6_run: got st=%b cfg=%0d want 10101 cfg=3", st, int_cfg_data);
    end
    tick(); tick();
    s_axis_tvalid = 2'b10;
    #1;
    n_vec++;
    if (st !== 5'b1_0_0_01) begin
      n_err++; $display("FAIL t6_stall: got %b want 10001", st);
    end
    tick();
    s_axis_tvalid = 2'b11;
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b1;
    mon_tready    = 1'b1;
    #1;
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t6_drain: got %b want 10000", st);
    end
    for (int i = 0; i < 7; i++) tick();
    mon_tvalid = 1'b0;
    tick();
    n_vec++;
    if (st !== 5'b1_0_0_00) begin
      n_err++; $display("FAIL t6_pending_left: got %b want 10000", st);
    end
    mon_tvalid = 1'b1;
    tick();
    mon_tvalid = 1'b0;
    tick();
    n_vec++;
    if (st !== 5'b0_0_0_00) begin
      n_err++; $display("FAIL t6_idle: got %b want 00000", st);
    end
    m_axis_tready = 1'b1;
    tick();
    n_vec++;
    if ({st, int_cfg_data} !== {5'b1_1_1_10, 32'd9}) begin
      n_err++; $display("FAIL t6_ch1: got st=%b cfg=%0d want 11110 cfg=9", st, int_cfg_data);
    end
    s_axis_tvalid = 2'b00;
    tick();
    n_vec++;
    if (st !== 5'b0_1_0_00) begin
      n_err++; $display("FAIL t6_no_sample_release: got %b want 01000", st);
    end
  endtask
`else
  task automatic test_stall_hold();
    s_axis_tvalid = 2'b11;
    cfg_burst     = 16'd3;
    cfg_ratio     = {32'd0, 32'd0};
    m_axis_tready = 1'b1;
    tick();
    n_vec++;
    if (st !== 5'b1_1_1_10) begin
      n_err++; $display("FAIL ts_run: got %b want 11110", st);
    end
    tick();
    s_axis_tvalid = 2'b01;
    for (int i = 0; i < 10; i++) begin
      #1;
      n_vec++;
      if (st !== 5'b1_1_0_10) begin
        n_err++; $display("FAIL ts_stall%0d: got %b want 11010", i, st);
      end
      tick();
    end
    s_axis_tvalid = 2'b11;
    #1;
    n_vec++;
    if (st !== 5'b1_1_1_10) begin
      n_err++; $display("FAIL ts_resume: got %b want 11110", st);
    end
    tick(); tick();
    n_vec++;
    if (st !== 5'b1_1_0_00) begin
      n_err++; $display("FAIL ts_drain: got %b want 11000", st);
    end
    m_axis_tready = 1'b0;
    mon_tvalid    = 1'b1;
    mon_tready    = 1'b1;
    tick(); tick(); tick();
    mon_tvalid = 1'b0;
    tick();
    n_vec++;
    if (st !== 5'b0_1_0_00) begin
      n_err++; $display("FAIL ts_idle: got %b want 01000", st);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_two_channels();
    test_single_channel();
    test_burst_zero();
    test_drain_hold();
    test_reset_mid_run();
`ifdef AXIS_INTERPOLATOR_ARBITER_EARLY_RELEASE_EN
    test_early_release();
`else
    test_stall_hold();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
